// File: rtl/eye_tracker_host_if.sv
// Byte-oriented host command interface: decodes read/write commands into one-hot
// register strobes and returns read data through a valid/ready handshake.
module eye_tracker_host_if #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  iRX_DATA,
  input  logic        iRX_VALID,
  output logic [7:0]  oTX_DATA,
  output logic        oTX_VALID,
  input  logic        iTX_READY,
  output logic [23:0] oWE_BIT,
  output logic [23:0] oRE_BIT,
  output logic [7:0]  oDATA,
  input  logic [7:0]  iRD,
  output logic        oERR
);

  localparam int NUM_REGS = 24;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_DATA = 3'd1;
  localparam logic [2:0] S_WRITE     = 3'd2;
  localparam logic [2:0] S_READ      = 3'd3;
  localparam logic [2:0] S_TX_WAIT   = 3'd4;

  logic [2:0]       state_reg, state_next;
  logic [4:0]       addr_reg, addr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [23:0]      we_reg, we_next;
  logic [23:0]      re_reg, re_next;
  logic [7:0]       data_reg, data_next;
  logic [7:0]       tx_data_reg, tx_data_next;
  logic             tx_valid_reg, tx_valid_next;
  logic             err_reg, err_next;

  logic [23:0]      rx_dec;
  logic [23:0]      addr_dec;
  logic             addr_ok;

  // Address decoders: out-of-range addresses decode to all zeros by construction.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_dec
      assign rx_dec[gi]   = (iRX_DATA[4:0] == 5'(gi));
      assign addr_dec[gi] = (addr_reg == 5'(gi));
    end
  endgenerate

  assign addr_ok = (addr_reg < 5'(NUM_REGS));

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    cnt_next      = cnt_reg;
    we_next       = '0;
    re_next       = '0;
    data_next     = data_reg;
    tx_data_next  = tx_data_reg;
    tx_valid_next = tx_valid_reg;
    err_next      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (iRX_VALID) begin
          addr_next = iRX_DATA[4:0];
          if (iRX_DATA[7]) begin
            state_next = S_WAIT_DATA;
            cnt_next   = '0;
          end else begin
            // Read strobe is launched straight from the command byte.
            state_next = S_READ;
            re_next    = rx_dec;
          end
        end
      end
      S_WAIT_DATA: begin
        if (iRX_VALID) begin
          data_next  = iRX_DATA;
          we_next    = addr_dec;
          state_next = S_WRITE;
        end else if (cnt_reg == CNT_LAST) begin
          err_next   = 1'b1;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      S_WRITE: begin
        err_next   = iRX_VALID;
        state_next = S_IDLE;
      end
      S_READ: begin
        err_next      = iRX_VALID;
        tx_data_next  = addr_ok ? iRD : 8'h00;
        tx_valid_next = 1'b1;
        state_next    = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        err_next = iRX_VALID;
        if (iTX_READY) begin
          tx_valid_next = 1'b0;
          state_next    = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= S_IDLE;
      addr_reg     <= '0;
      cnt_reg      <= '0;
      we_reg       <= '0;
      re_reg       <= '0;
      data_reg     <= 8'h00;
      tx_data_reg  <= 8'h00;
      tx_valid_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      cnt_reg      <= cnt_next;
      we_reg       <= we_next;
      re_reg       <= re_next;
      data_reg     <= data_next;
      tx_data_reg  <= tx_data_next;
      tx_valid_reg <= tx_valid_next;
      err_reg      <= err_next;
    end
  end

  assign oWE_BIT   = we_reg;
  assign oRE_BIT   = re_reg;
  assign oDATA     = data_reg;
  assign oTX_DATA  = tx_data_reg;
  assign oTX_VALID = tx_valid_reg;
  assign oERR      = err_reg;

endmodule

// File: tb/tb_eye_tracker_host_if.sv
// Randomized bench for eye_tracker_host_if: a register-file model predicts every
// strobe, response byte and error pulse from the command/data byte stream.
module tb_eye_tracker_host_if;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic [23:0] we_bit, re_bit;
  logic [7:0]  wdata;
  logic [7:0]  rd_data;
  logic        err;

  // Second instance with the shortest legal timeout.
  logic [7:0]  rx1_data = 8'h00;
  logic        rx1_valid = 1'b0;
  logic        tx1_ready = 1'b1;
  logic [7:0]  txd1, d1;
  logic        txv1, err1;
  logic [23:0] we1, re1;
  logic [7:0]  rd1 = 8'h00;

  int n_checks = 0;
  int n_errors = 0;
  logic       err_due = 1'b0;
  logic [7:0] model_mem [24];
  logic [7:0] last_data = 8'h00;
  logic [7:0] regblk [24];

  always #5 clk = ~clk;

  eye_tracker_host_if #(.TIMEOUT_CYCLES(TO)) u_dut (
    .CLK(clk), .RST(rst), .iRX_DATA(rx_data), .iRX_VALID(rx_valid),
    .oTX_DATA(tx_data), .oTX_VALID(tx_valid), .iTX_READY(tx_ready),
    .oWE_BIT(we_bit), .oRE_BIT(re_bit), .oDATA(wdata), .iRD(rd_data), .oERR(err)
  );

  eye_tracker_host_if #(.TIMEOUT_CYCLES(1)) u_dut1 (
    .CLK(clk), .RST(rst), .iRX_DATA(rx1_data), .iRX_VALID(rx1_valid),
    .oTX_DATA(txd1), .oTX_VALID(txv1), .iTX_READY(tx1_ready),
    .oWE_BIT(we1), .oRE_BIT(re1), .oDATA(d1), .iRD(rd1), .oERR(err1)
  );

  // Register block driven only by the DUT's strobes; garbage when nothing selected.
  always @(posedge clk)
    for (int i = 0; i < 24; i++)
      if (we_bit[i]) regblk[i] <= wdata;

  always_comb begin
    rd_data = 8'hEE;
    for (int i = 0; i < 24; i++)
      if (re_bit[i]) rd_data = regblk[i];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("err", 32'(err), 32'(err_due));
    err_due = 1'b0;
    check("strobe_onehot", 32'(($countones(we_bit) + $countones(re_bit)) <= 1), 32'd1);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  function automatic logic [31:0] onehot(input logic [4:0] a);
    return (a < 5'd24) ? (32'd1 << a) : 32'd0;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, 32'(we_bit), 32'd0);
    check({tag, "_re"}, 32'(re_bit), 32'd0);
    check({tag, "_data"}, 32'(wdata), 32'd0);
    check({tag, "_txd"}, 32'(tx_data), 32'd0);
    check({tag, "_txv"}, 32'(tx_valid), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic do_write(input logic [7:0] cmd, input logic [7:0] data, input int gap, input bit stray);
    logic [4:0] a;
    a = cmd[4:0];
    send(cmd | 8'h80);
    check("wr_wait_we", 32'(we_bit), 32'd0);
    repeat (gap) tick();
    send(data);
    check("wr_we", 32'(we_bit), onehot(a));
    check("wr_data", 32'(wdata), 32'(data));
    check("wr_re", 32'(re_bit), 32'd0);
    if (stray) begin
      err_due = 1'b1;
      send(8'($urandom));
    end else begin
      tick();
    end
    check("wr_we_off", 32'(we_bit), 32'd0);
    check("wr_data_hold", 32'(wdata), 32'(data));
    if (a < 5'd24) model_mem[a] = data;
    last_data = data;
    $display("write cmd=%02h data=%02h gap=%0d stray=%0d", cmd | 8'h80, data, gap, stray);
  endtask

  // stray: 0 none, 1 byte during READ, 2 byte during TX_WAIT
  task automatic do_read(input logic [7:0] cmd, input int hold_in, input int stray);
    logic [4:0] a;
    logic [7:0] exp_tx;
    int hold;
    a = cmd[4:0];
    exp_tx = (a < 5'd24) ? model_mem[a] : 8'h00;
    hold = (stray == 2 && hold_in == 0) ? 1 : hold_in;
    tx_ready = 1'b0;
    send(cmd & 8'h7F);
    check("rd_re", 32'(re_bit), onehot(a));
    check("rd_we", 32'(we_bit), 32'd0);
    check("rd_txv_early", 32'(tx_valid), 32'd0);
    if (stray == 1) begin
      err_due = 1'b1;
      send(8'($urandom));
    end else begin
      tick();
    end
    check("rd_txv", 32'(tx_valid), 32'd1);
    check("rd_txd", 32'(tx_data), 32'(exp_tx));
    check("rd_re_off", 32'(re_bit), 32'd0);
    for (int h = 0; h < hold; h++) begin
      if (stray == 2 && h == 0) begin
        err_due = 1'b1;
        send(8'h55);
      end else begin
        tick();
      end
      check("rd_hold_txv", 32'(tx_valid), 32'd1);
      check("rd_hold_txd", 32'(tx_data), 32'(exp_tx));
      check("rd_hold_strobe", 32'(we_bit | re_bit), 32'd0);
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("rd_txv_done", 32'(tx_valid), 32'd0);
    check("rd_data_kept", 32'(wdata), 32'(last_data));
    $display("read  cmd=%02h resp=%02h hold=%0d stray=%0d", cmd & 8'h7F, exp_tx, hold, stray);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Timeout of one cycle: data in the first WAIT_DATA cycle is accepted.
    rx1_data = 8'h85; rx1_valid = 1'b1;
    @(posedge clk); #1;
    rx1_data = 8'h3C;
    @(posedge clk); #1;
    rx1_valid = 1'b0;
    check("to1_we", 32'(we1), 32'h20);
    check("to1_data", 32'(d1), 32'h3C);
    check("to1_err", 32'(err1), 32'd0);
    @(posedge clk); #1;
    rx1_data = 8'h85; rx1_valid = 1'b1;
    @(posedge clk); #1;
    rx1_valid = 1'b0;
    @(posedge clk); #1;
    check("to1_late_err", 32'(err1), 32'd1);
    check("to1_late_we", 32'(we1), 32'd0);
    rx1_data = 8'h47; rx1_valid = 1'b1;
    @(posedge clk); #1;
    rx1_valid = 1'b0;
    check("to1_next_is_cmd", 32'(re1), 32'h80);
    check("to1_next_we", 32'(we1), 32'd0);
    $display("timeout1 checks done");
    tick();

    // Populate every register through the interface.
    for (int a = 0; a < 24; a++)
      do_write(8'(a) | (8'($urandom_range(0, 3)) << 5), 8'($urandom), $urandom_range(0, TO - 1), 1'b0);

    do_write(8'h82, 8'h40, 0, 1'b0);
    do_write(8'h90, 8'h5A, TO - 1, 1'b0);
    do_read(8'h10, 5, 0);
    do_read(8'h1F, 2, 0);
    do_write(8'h9F, 8'h11, 0, 1'b0);
    do_read(8'h05, 3, 2);
    do_read(8'h17, 0, 1);
    do_write(8'h97, 8'hA5, 2, 1'b1);

    // Timeout: command then silence.
    send(8'h83);
    repeat (TO - 1) tick();
    err_due = 1'b1;
    tick();
    check("timeout_we", 32'(we_bit), 32'd0);
    $display("timeout after cmd=83");
    do_read(8'h03, 1, 0);

    // Reset mid WAIT_DATA.
    send(8'h82);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_wait_async");
    @(posedge clk); #1;
    check_all_zero("rst_wait");
    rst = 1'b0;
    last_data = 8'h00;
    tick();
    check("rst_wait_no_we", 32'(we_bit), 32'd0);
    $display("reset in WAIT_DATA");
    do_read(8'h02, 1, 0);

    // Reset mid TX_WAIT.
    send(8'h04);
    tick();
    check("pre_rst_txv", 32'(tx_valid), 32'd1);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_tx_async");
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    check("rst_tx_txv", 32'(tx_valid), 32'd0);
    $display("reset in TX_WAIT");
    do_read(8'h04, 0, 0);

    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 1) == 0)
        do_write(8'($urandom), 8'($urandom), $urandom_range(0, TO - 1), ($urandom_range(0, 3) == 0));
      else
        do_read(8'($urandom), $urandom_range(0, 5),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
